event_nibble_sender: RTL

- Upstream feeder of the chip-output tristate stage. It buffers 20-bit event words in a small FIFO and serialises each word as four 5-bit nibbles on databus[4:0].
- Each nibble is qualified by a DATAREADY strobe on databus[5], using a 4-phase req/ack handshake with the off-chip reader.
- The block owns all timing of the external interface. The downstream buffer stage only drives pins.

---
 rtl/event_nibble_sender.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/event_nibble_sender.sv
// Event FIFO plus serialiser: each buffered word leaves as WORD_WIDTH/NIBBLE_WIDTH
// nibbles on databus[NIBBLE_WIDTH-1:0], each one qualified by a 4-phase DATAREADY/ack handshake.
module event_nibble_sender #(
    parameter int WORD_WIDTH   = 20,
    parameter int NIBBLE_WIDTH = 5,
    parameter int FIFO_DEPTH   = 4,
    parameter int SETUP_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          event_valid,
    input  logic [WORD_WIDTH-1:0]         event_data,
    output logic                          event_ready,
    input  logic                          ack,
    output logic [NIBBLE_WIDTH:0]         databus,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int NUM_NIB = WORD_WIDTH / NIBBLE_WIDTH;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam int IW      = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
    localparam int SW      = $clog2(SETUP_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LOAD, PRESENT, WAIT_HI, WAIT_LO} state_t;

    state_t                  state, state_nxt;
    logic                    ack_m, ack_s;
    logic [WORD_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic                    push, pop;
    logic [WORD_WIDTH-1:0]   shift_q, shift_nxt, shifted;
    logic [IW-1:0]           nib_idx, idx_nxt;
    logic [SW-1:0]           setup_cnt, cnt_nxt;
    logic [NIBBLE_WIDTH-1:0] nib_nxt;
    logic                    dr_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= ack;
            ack_s <= ack_m;
        end
    end

    // event_ready depends only on the registered count, so a pop in the same
    // cycle never rescues a write that arrives while full.
    assign event_ready = (fifo_count != CW'(FIFO_DEPTH));
    assign push        = event_valid && event_ready;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= event_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (event_valid && !event_ready) overflow <= 1'b1;
        end
    end

    assign shifted = shift_q >> NIBBLE_WIDTH;

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_q;
        idx_nxt   = nib_idx;
        cnt_nxt   = setup_cnt;
        nib_nxt   = databus[NIBBLE_WIDTH-1:0];
        dr_nxt    = databus[NIBBLE_WIDTH];
        pop       = 1'b0;
        case (state)
            IDLE: begin
                nib_nxt = '0;
                dr_nxt  = 1'b0;
                if (fifo_count != '0) state_nxt = LOAD;
            end
            LOAD: begin
                pop       = 1'b1;
                shift_nxt = mem[rd_ptr];
                nib_nxt   = mem[rd_ptr][NIBBLE_WIDTH-1:0];
                idx_nxt   = '0;
                cnt_nxt   = '0;
                dr_nxt    = 1'b0;
                state_nxt = PRESENT;
            end
            PRESENT: begin
                // Setup time only accrues once the reader has let go of ack.
                if (!ack_s) begin
                    if (setup_cnt == SW'(SETUP_CYCLES - 1)) begin
                        dr_nxt    = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = WAIT_HI;
                    end else begin
                        cnt_nxt = setup_cnt + 1'b1;
                    end
                end
            end
            WAIT_HI: begin
                if (ack_s) begin
                    dr_nxt    = 1'b0;
                    state_nxt = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!ack_s) begin
                    if (nib_idx == IW'(NUM_NIB - 1)) begin
                        nib_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt   = nib_idx + 1'b1;
                        shift_nxt = shifted;
                        nib_nxt   = shifted[NIBBLE_WIDTH-1:0];
                        state_nxt = PRESENT;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift_q   <= '0;
            nib_idx   <= '0;
            setup_cnt <= '0;
            databus   <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_q   <= shift_nxt;
            nib_idx   <= idx_nxt;
            setup_cnt <= cnt_nxt;
            databus   <= {dr_nxt, nib_nxt};
            busy      <= (state_nxt != IDLE);
        end
    end

endmodule
